// File: rtl/mem_arbiter_pkg.sv
// Shared types for the line-memory arbiter between ifetch and MEM stage.
// Optional round-robin tie-break is enabled with MEM_ARB_RR_EN.
package mem_arbiter_pkg;

    typedef logic [11:0]  lc3b_wb_adr;
    typedef logic [127:0] lc3b_line;
    typedef logic [15:0]  lc3b_word;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } lc3b_arb_state;

    typedef enum logic {
        ARB_SRC_I,
        ARB_SRC_D
    } lc3b_arb_src;

    localparam lc3b_word SEL_ALL = 16'hFFFF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of ifetch, data and downstream memory signals around the arbiter.
// slave: arbiter view; master: requesters plus downstream memory view.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic       i_read;
    lc3b_wb_adr i_address;
    lc3b_line   i_rdata;
    logic       i_resp;

    logic       d_read;
    logic       d_write;
    lc3b_wb_adr d_address;
    lc3b_line   d_wdata;
    lc3b_word   d_sel;
    lc3b_line   d_rdata;
    logic       d_resp;

    logic       m_read;
    logic       m_write;
    lc3b_wb_adr m_address;
    lc3b_line   m_wdata;
    lc3b_word   m_sel;
    lc3b_line   m_rdata;
    logic       m_resp;

    modport slave (
        input  i_read, i_address,
        input  d_read, d_write, d_address, d_wdata, d_sel,
        input  m_rdata, m_resp,
        output i_rdata, i_resp,
        output d_rdata, d_resp,
        output m_read, m_write, m_address, m_wdata, m_sel
    );

    modport master (
        output i_read, i_address,
        output d_read, d_write, d_address, d_wdata, d_sel,
        output m_rdata, m_resp,
        input  i_rdata, i_resp,
        input  d_rdata, d_resp,
        input  m_read, m_write, m_address, m_wdata, m_sel
    );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational grant pick from the live requests while the arbiter idles.
// MEM_ARB_RR_EN makes a double request alternate against last_served.
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
    input  logic        i_req,
    input  logic        d_req,
    input  logic        starve_hit,
    input  lc3b_arb_src last_served,
    output logic        grant_valid,
    output lc3b_arb_src grant_src
);

    lc3b_arb_src both_src;

`ifdef MEM_ARB_RR_EN
    always_comb begin
        both_src = (last_served == ARB_SRC_I) ? ARB_SRC_D : ARB_SRC_I;
        if (starve_hit) both_src = ARB_SRC_I;
    end
`else
    logic unused_last_served;
    assign unused_last_served = last_served;

    assign both_src = starve_hit ? ARB_SRC_I : ARB_SRC_D;
`endif

    always_comb begin
        grant_valid = i_req | d_req;
        grant_src   = ARB_SRC_D;
        unique case (1'b1)
            (d_req & ~i_req): grant_src = ARB_SRC_D;
            (i_req & ~d_req): grant_src = ARB_SRC_I;
            (i_req &  d_req): grant_src = both_src;
            default:          grant_src = ARB_SRC_D;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one downstream line port between ifetch and data, data first with a starvation guard.
// Define MEM_ARB_RR_EN to alternate grants when both sides request together.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    lc3b_arb_state state_q, state_d;
    logic [3:0]    starve_cnt_q, starve_cnt_d;

    logic          d_req;
    logic          starve_hit;
    logic          grant_valid;
    lc3b_arb_src   grant_src;
    lc3b_arb_src   last_served;

    assign d_req      = bus.d_read | bus.d_write;
    assign starve_hit = (starve_cnt_q == STARVE_LIM);

`ifdef MEM_ARB_RR_EN
    lc3b_arb_src last_served_q, last_served_d;
    assign last_served = last_served_q;
`else
    assign last_served = ARB_SRC_I;
`endif

    mem_arbiter_pick u_pick (
        .i_req       (bus.i_read),
        .d_req       (d_req),
        .starve_hit  (starve_hit),
        .last_served (last_served),
        .grant_valid (grant_valid),
        .grant_src   (grant_src)
    );

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
`ifdef MEM_ARB_RR_EN
        last_served_d = last_served_q;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
`ifdef MEM_ARB_RR_EN
                    last_served_d = grant_src;
`endif
                    if (grant_src == ARB_SRC_D) begin
                        state_d = ARB_SERVE_D;
                        // Only a data grant that leaves ifetch waiting counts toward starvation
                        if (!bus.i_read)     starve_cnt_d = '0;
                        else if (!starve_hit) starve_cnt_d = starve_cnt_q + 4'd1;
                    end else begin
                        state_d      = ARB_SERVE_I;
                        starve_cnt_d = '0;
                    end
                end
            end
            ARB_SERVE_I,
            ARB_SERVE_D: begin
                if (bus.m_resp) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus.m_read    = 1'b0;
        bus.m_write   = 1'b0;
        bus.m_address = '0;
        bus.m_wdata   = '0;
        bus.m_sel     = '0;
        bus.i_rdata   = '0;
        bus.i_resp    = 1'b0;
        bus.d_rdata   = '0;
        bus.d_resp    = 1'b0;
        unique case (state_q)
            ARB_SERVE_I: begin
                bus.m_read    = bus.i_read;
                bus.m_address = bus.i_address;
                bus.m_sel     = SEL_ALL;
                bus.i_rdata   = bus.m_rdata;
                bus.i_resp    = bus.m_resp;
            end
            ARB_SERVE_D: begin
                bus.m_read    = bus.d_read;
                bus.m_write   = bus.d_write;
                bus.m_address = bus.d_address;
                bus.m_wdata   = bus.d_wdata;
                bus.m_sel     = bus.d_sel;
                bus.d_rdata   = bus.m_rdata;
                bus.d_resp    = bus.m_resp;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_served_q <= ARB_SRC_I;
`endif
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
`ifdef MEM_ARB_RR_EN
            last_served_q <= last_served_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random checks of mem_arbiter against a transaction-level model.
// Expected grant orders follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(SM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit i_pend, i_auto, d_pend, d_auto, d_wr, rand_mode;
    lc3b_wb_adr i_addr, d_addr;
    lc3b_line   d_wdata;
    lc3b_word   d_sel;

    bit mem_busy, use_force;
    int mem_wait, lat_force;
    lc3b_line mem_data, force_data, i_rd_cap;

    int owner;      // 0 none, 1 ifetch, 2 data
    int d_streak;
    int last_src;
    string log;
    int n_i_resp, n_d_resp, last_resp_cyc, last_gap;
    bit prev_active;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_str(string tag, string obs, string exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %s expected %s", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_ctl"}, 128'({bus.m_read, bus.m_write, bus.i_resp, bus.d_resp}), 128'(0));
        chk({tag, "_adr"}, 128'(bus.m_address), 128'(0));
        chk({tag, "_sel"}, 128'(bus.m_sel), 128'(0));
        chk({tag, "_wd"}, bus.m_wdata, 128'(0));
        chk({tag, "_ird"}, bus.i_rdata, 128'(0));
        chk({tag, "_drd"}, bus.d_rdata, 128'(0));
    endtask

    function automatic lc3b_line rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic new_i();
        i_pend = 1'b1;
        i_addr = 12'($urandom);
    endtask

    task automatic new_d();
        d_pend  = 1'b1;
        d_wr    = 1'($urandom_range(0, 1));
        d_addr  = 12'($urandom);
        d_wdata = rnd_line();
        d_sel   = 16'($urandom);
    endtask

    task automatic drive_zero();
        bus.i_read = 1'b0; bus.i_address = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0;
        bus.d_address = '0; bus.d_wdata = '0; bus.d_sel = '0;
        bus.m_rdata = '0; bus.m_resp = 1'b0;
    endtask

    task automatic model_reset();
        owner = 0; d_streak = 0; last_src = 1;
        mem_busy = 1'b0; mem_wait = 0;
        i_pend = 1'b0; d_pend = 1'b0;
        i_auto = 1'b0; d_auto = 1'b0; rand_mode = 1'b0;
        prev_active = 1'b0;
    endtask

    // Arbitration rule: single requester wins; on a tie data wins unless
    // ifetch has already watched SM data grants (or it is ifetch's turn in RR)
    function automatic int pick(bit ir, bit dr);
        if (!ir && !dr) return 0;
        if (ir && !dr) return 1;
        if (dr && !ir) return 2;
        if (d_streak == SM) return 1;
`ifdef MEM_ARB_RR_EN
        return (last_src == 1) ? 2 : 1;
`else
        return 2;
`endif
    endfunction

    task automatic step();
        logic e_mr, e_mw, e_ir, e_dr, mr, act;
        lc3b_wb_adr e_adr;
        lc3b_line e_wd, e_ird, e_drd;
        lc3b_word e_sel;
        int cur, lat;
        @(negedge clk);
        cyc++;
        mr = mem_busy && (mem_wait == 0);
        bus.i_read    = i_pend;
        bus.i_address = i_addr;
        bus.d_read    = d_pend & ~d_wr;
        bus.d_write   = d_pend & d_wr;
        bus.d_address = d_addr;
        bus.d_wdata   = d_wdata;
        bus.d_sel     = d_sel;
        bus.m_resp    = mr;
        bus.m_rdata   = mr ? mem_data : rnd_line();
        #1;
        cur = owner;
        e_mr = 0; e_mw = 0; e_ir = 0; e_dr = 0;
        e_adr = '0; e_wd = '0; e_sel = '0; e_ird = '0; e_drd = '0;
        if (cur == 1) begin
            e_mr = i_pend; e_adr = i_addr; e_sel = 16'hFFFF;
            e_ird = bus.m_rdata; e_ir = mr;
        end else if (cur == 2) begin
            e_mr = d_pend & ~d_wr; e_mw = d_pend & d_wr;
            e_adr = d_addr; e_wd = d_wdata; e_sel = d_sel;
            e_drd = bus.m_rdata; e_dr = mr;
        end
        chk("ctl", 128'({bus.m_read, bus.m_write, bus.i_resp, bus.d_resp}),
            128'({e_mr, e_mw, e_ir, e_dr}));
        chk("m_address", 128'(bus.m_address), 128'(e_adr));
        chk("m_wdata", bus.m_wdata, e_wd);
        chk("m_sel", 128'(bus.m_sel), 128'(e_sel));
        chk("i_rdata", bus.i_rdata, e_ird);
        chk("d_rdata", bus.d_rdata, e_drd);
        chk("resp_excl", 128'(bus.i_resp & bus.d_resp), 128'(0));

        if (bus.i_resp === 1'b1) begin
            log = {log, "I"}; n_i_resp++; last_resp_cyc = cyc; i_rd_cap = bus.i_rdata;
        end
        if (bus.d_resp === 1'b1) begin
            log = {log, "D"}; n_d_resp++; last_resp_cyc = cyc;
        end
        act = bus.m_read | bus.m_write;
        if (act === 1'b1 && !prev_active) last_gap = cyc - last_resp_cyc;
        prev_active = (act === 1'b1);

        if (mr) mem_busy = 1'b0;
        else if (mem_busy) mem_wait--;
        else if (cur != 0) begin
            lat = (lat_force != 0) ? lat_force : int'($urandom_range(1, 4));
            mem_busy = 1'b1;
            mem_wait = lat - 1;
            mem_data = use_force ? force_data : rnd_line();
        end

        if (cur == 0) begin
            owner = pick(i_pend, d_pend);
            if (owner == 2) d_streak = i_pend ? ((d_streak < SM) ? d_streak + 1 : SM) : 0;
            if (owner == 1) d_streak = 0;
            if (owner != 0) last_src = owner;
        end else if (mr) owner = 0;

        if (cur == 1 && mr) i_pend = 1'b0;
        if (cur == 2 && mr) d_pend = 1'b0;
        if (!i_pend && (i_auto || (rand_mode && $urandom_range(0, 2) == 0))) new_i();
        if (!d_pend && (d_auto || (rand_mode && $urandom_range(0, 2) == 0))) new_d();
    endtask

    task automatic run_resps(int n, int budget, string tag);
        int k = 0;
        while (log.len() < n && k < budget) begin
            step();
            k++;
        end
        checks++;
        assert (log.len() >= n) else begin
            errors++;
            $error("FAIL %s_timeout: observed %0d responses expected %0d", tag, log.len(), n);
        end
    endtask

    task automatic drain(string tag);
        int k = 0;
        i_auto = 1'b0; d_auto = 1'b0; rand_mode = 1'b0;
        while ((i_pend || d_pend || owner != 0 || mem_busy) && k < 100) begin
            step();
            k++;
        end
        checks++;
        assert (k < 100) else begin
            errors++;
            $error("FAIL %s_drain: observed %0d cycles expected under 100", tag, k);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        drive_zero();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int k, ni0, nd0;
        string exp4;
        drive_zero();
        model_reset();
        lat_force = 0; use_force = 1'b0;
        force_data = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_sel = '0; d_wr = 1'b0;
        log = ""; last_resp_cyc = 0; last_gap = 0;

        repeat (2) @(negedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // Test 1: async reset while serving a data read
        d_pend = 1'b1; d_wr = 1'b0; d_addr = 12'h155;
        d_sel = 16'hFFFF; d_wdata = '0; lat_force = 4;
        k = 0;
        while (owner != 2 && k < 10) begin step(); k++; end
        step();
        chk("t1_pre_mread", 128'(bus.m_read), 128'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("t1_rst_ctl", 128'({bus.m_read, bus.m_write, bus.i_resp, bus.d_resp}), 128'(0));
        drive_zero();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();

        // Test 2: lone ifetch read with 3-cycle memory latency
        lat_force = 3; use_force = 1'b1;
        ni0 = n_i_resp; nd0 = n_d_resp; log = "";
        i_pend = 1'b1; i_addr = 12'h0A3;
        run_resps(1, 20, "t2");
        repeat (3) step();
        chk("t2_ipulse", 128'(n_i_resp - ni0), 128'(1));
        chk("t2_dresp", 128'(n_d_resp - nd0), 128'(0));
        chk("t2_irdata", i_rd_cap, force_data);
        chk("t2_lat", 128'(last_resp_cyc - (last_gap > 0 ? 0 : 0)) - 128'(last_resp_cyc), 128'(0));
        lat_force = 0; use_force = 1'b0;

        // Test 3: simultaneous data write and ifetch read
        log = "";
        i_pend = 1'b1; i_addr = 12'h3C0;
        d_pend = 1'b1; d_wr = 1'b1; d_addr = 12'h7E1;
        d_wdata = rnd_line(); d_sel = 16'h0003;
        run_resps(2, 40, "t3");
        chk_str("t3_order", log, "DI");
        chk("t3_gap", 128'(last_gap), 128'(2));
        drain("t3");

        // Tests 4/5: both sides keep requesting back to back from reset
        apply_reset();
`ifdef MEM_ARB_RR_EN
        exp4 = "DIDIDIDIDI";
`else
        exp4 = "DDDDIDDDDI";
`endif
        log = "";
        i_auto = 1'b1; d_auto = 1'b1;
        new_i(); new_d();
        run_resps(10, 300, "t4");
        chk_str("t4_order", log.substr(0, 9), exp4);
        drain("t4");

        // Random traffic against the model
        log = "";
        rand_mode = 1'b1;
        repeat (400) step();
        drain("rand");
        chk("rand_activity", 128'(log.len() > 20), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
